wb_queue: RTL and testbench
===========================

Name: wb_queue

Overview:
- 2-wide in-order write-back queue that drives the register file's write ports 0 and 1 (we/waddr/wdata).
- Accepts up to two results per cycle from the execute/memory pipes, buffers them in a circular FIFO and drains up to two per cycle, oldest first.
- Address space: GPR 1..31 plus HILO at address 32 (64-bit data). Address 0 is never written.

Parameters:
- DEPTH, 8, FIFO entries; power of two, >= 4
- AW, 6, register address width
- DW, 64, write data width (GPR uses [31:0]; HILO uses all 64)
- CW, $clog2(DEPTH)+1, width of count

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous queue clear (exception/redirect)
- stall  in  1  write-back stall; no pops while high
- in0_valid  in  1  producer 0 result valid (older of the pair)
- in0_ready  out  1  producer 0 accepted this cycle when valid&ready
- in0_waddr  in  AW  destination address
- in0_wdata  in  DW  result data
- in1_valid  in  1  producer 1 result valid (younger)
- in1_ready  out  1  producer 1 accept
- in1_waddr  in  AW  destination address
- in1_wdata  in  DW  result data
- we0  out  1  regfile write port 0 enable (older entry)
- waddr0  out  AW  port 0 address
- wdata0  out  DW  port 0 data
- we1  out  1  regfile write port 1 enable (younger entry)
- waddr1  out  AW  port 1 address
- wdata1  out  DW  port 1 data
- count  out  CW  current occupancy
- empty  out  1  count==0

Behaviour:
- Reset (async): rd_ptr=wr_ptr=0, count=0, empty=1. Combinationally this gives we0=we1=0, waddr0/1=0, wdata0/1=0, and in0_ready=in1_ready=1 (while flush is low).
- Zeroing rule: whenever weN=0, waddrN and wdataN are 0. The regfile read bypass compares waddr without checking we, so a stale address would forward bogus data.
- Write ports are combinational from the FIFO head: entry[rd_ptr] goes to port 0, entry[rd_ptr+1] to port 1. Latency from accept at edge N to port visibility is 1 cycle.
- Pop count: pop = (stall|flush) ? 0 : min(count,2). we0 = pop>=1, we1 = pop==2. Port 0 is always older, so a same-address pair resolves to the younger value, matching the regfile's port-1-last write order.
- Ready (from current count only; same-cycle pops give no credit):
  - free = DEPTH-count
  - in0_ready = !flush & free>=1
  - in1_ready = !flush & free >= (in0_valid ? 2 : 1)
- Enqueue order: in0 before in1. in1 may be accepted alone when in0_valid=0.
- Address 0: a handshake with waddr==0 completes (ready honoured) but nothing is stored and count does not increase.
- Update: wr_ptr += stored, rd_ptr += pop, both mod DEPTH with natural wrap. count_next = count + stored - pop.
- Full (count==DEPTH): both readies low; pops continue if not stalled.
- Empty + stall: outputs stay zero; pushes still accepted.
- flush: readies forced 0, we0/we1 forced 0. Next edge sets rd_ptr=wr_ptr=0 and count=0. Flush beats stall and beats push.
- Reset mid-operation discards all entries immediately; there is no partial write.

Optional Feature:
- Macro: WBQ_PERF_EN
- With it defined: output perf_bp [31:0] is added. It is a saturating counter, reset to 0, that increments on every cycle where (in0_valid & !in0_ready) | (in1_valid & !in1_ready). It holds at 32'hFFFF_FFFF and is not cleared by flush.
- Without it: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- Reset, idle: rst pulse, no valids -> we0=we1=0, waddr0=waddr1=0, wdata0=wdata1=0, count=0, empty=1, both readies 1.
- Dual push, empty queue: in0 {5,0x11}, in1 {32,0x0000_0002_0000_0003} at edge N -> cycle N+1: we0=1 waddr0=5 wdata0=0x11, we1=1 waddr1=32 wdata1=0x0000_0002_0000_0003; count=0 after edge N+1.
- Fill under stall: stall=1, push 2/cycle for 4 cycles (DEPTH=8) -> count=8, readies 0, we0=we1=0. Release stall -> entries drain 2/cycle in push order with port 0 older; ptr wrap verified on a second fill.
- Same-address pair: in0 {7,0xA}, in1 {7,0xB} -> waddr0=waddr1=7 in the same cycle, wdata0=0xA, wdata1=0xB.
- Address 0 and in1-only: in0 {0,0xFF} valid, in1 {9,0x9} -> both ready=1, count+1 only, next cycle we0=1 waddr0=9, we1=0. Separately, in0_valid=0 with count=7 -> in1_ready=1.
- Flush/reset mid-op: count=5, assert flush with both valids high -> readies 0, we0=we1=0, next cycle count=0. Repeat with async rst between edges -> outputs zero immediately. With WBQ_PERF_EN, perf_bp counts each blocked-valid cycle.

Source files
------------

// File: rtl/wb_queue.sv
// rtl/wb_queue.sv - 2-wide in-order write-back queue driving regfile write ports 0/1
// Optional feature macro: WBQ_PERF_EN (adds perf_bp backpressure cycle counter)
module wb_queue #(
  parameter int DEPTH = 8,
  parameter int AW    = 6,
  parameter int DW    = 64,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          stall,
  input  logic          in0_valid,
  output logic          in0_ready,
  input  logic [AW-1:0] in0_waddr,
  input  logic [DW-1:0] in0_wdata,
  input  logic          in1_valid,
  output logic          in1_ready,
  input  logic [AW-1:0] in1_waddr,
  input  logic [DW-1:0] in1_wdata,
  output logic          we0,
  output logic [AW-1:0] waddr0,
  output logic [DW-1:0] wdata0,
  output logic          we1,
  output logic [AW-1:0] waddr1,
  output logic [DW-1:0] wdata1,
  output logic [CW-1:0] count,
`ifdef WBQ_PERF_EN
  output logic          empty,
  output logic [31:0]   perf_bp
`else
  output logic          empty
`endif
);

  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr1;
  logic [PW-1:0] wr_ptr1;
  logic [CW-1:0] free;
  logic [CW-1:0] pop;
  logic [CW-1:0] stored;
  logic          st0;
  logic          st1;

  assign rd_ptr1 = rd_ptr + PW'(1);
  assign wr_ptr1 = wr_ptr + PW'(1);

  // Readiness looks only at the current occupancy; pops in this cycle give no credit.
  assign free      = CW'(DEPTH) - count;
  assign in0_ready = !flush && (free >= CW'(1));
  assign in1_ready = !flush && (free >= (in0_valid ? CW'(2) : CW'(1)));

  // Address 0 handshakes complete but are dropped.
  assign st0    = in0_valid && in0_ready && (in0_waddr != '0);
  assign st1    = in1_valid && in1_ready && (in1_waddr != '0);
  assign stored = CW'(st0) + CW'(st1);

  always_comb begin
    pop = '0;
    if (!(stall || flush)) begin
      pop = (count >= CW'(2)) ? CW'(2) : count;
    end
  end

  assign we0   = (pop != '0);
  assign we1   = (pop == CW'(2));
  assign empty = (count == '0);

  // Disabled ports present zeros: the regfile bypass compares waddr without we.
  assign waddr0 = we0 ? addr_mem[rd_ptr]  : '0;
  assign wdata0 = we0 ? data_mem[rd_ptr]  : '0;
  assign waddr1 = we1 ? addr_mem[rd_ptr1] : '0;
  assign wdata1 = we1 ? data_mem[rd_ptr1] : '0;

  always_ff @(posedge clk) begin
    if (st0) begin
      addr_mem[wr_ptr] <= in0_waddr;
      data_mem[wr_ptr] <= in0_wdata;
    end
    if (st1) begin
      addr_mem[st0 ? wr_ptr1 : wr_ptr] <= in1_waddr;
      data_mem[st0 ? wr_ptr1 : wr_ptr] <= in1_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PW'(pop);
      wr_ptr <= wr_ptr + PW'(stored);
      count  <= count + stored - pop;
    end
  end

`ifdef WBQ_PERF_EN
  logic bp;
  assign bp = (in0_valid && !in0_ready) || (in1_valid && !in1_ready);

  // Saturating, survives flush; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_bp <= '0;
    end else if (bp && (perf_bp != 32'hFFFF_FFFF)) begin
      perf_bp <= perf_bp + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_queue.sv
// tb/tb_wb_queue.sv - randomized bench for wb_queue against a queue-based reference model
module tb_wb_queue;

  logic        clk, rst, flush, stall;
  logic        in0_valid, in0_ready, in1_valid, in1_ready;
  logic [5:0]  in0_waddr, in1_waddr, waddr0, waddr1;
  logic [63:0] in0_wdata, in1_wdata, wdata0, wdata1;
  logic        we0, we1, empty;
  logic [3:0]  count;
`ifdef WBQ_PERF_EN
  logic [31:0] perf_bp;
`endif

  wb_queue dut (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_waddr(in0_waddr), .in0_wdata(in0_wdata),
    .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_waddr(in1_waddr), .in1_wdata(in1_wdata),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .count(count),
`ifdef WBQ_PERF_EN
    .empty(empty),
    .perf_bp(perf_bp)
`else
    .empty(empty)
`endif
  );

  typedef struct packed {
    logic [5:0]  a;
    logic [63:0] d;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_perf;
  int          total = 0;
  int          bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [5:0] rnd_addr();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel == 0) return 6'd0;
    if (sel == 1) return 6'd32;
    if (sel <= 4) return 6'($urandom_range(1, 3));
    return 6'($urandom_range(1, 31));
  endfunction

  // One cycle: drive, check combinational outputs against the model, clock, advance the model.
  task automatic step(input logic fl, input logic st,
                      input logic v0, input logic [5:0] a0, input logic [63:0] d0,
                      input logic v1, input logic [5:0] a1, input logic [63:0] d1);
    int   n, fr, np;
    logic r0, r1;
    ent_t e;
    @(negedge clk);
    flush = fl; stall = st;
    in0_valid = v0; in0_waddr = a0; in0_wdata = d0;
    in1_valid = v1; in1_waddr = a1; in1_wdata = d1;
    #1;
    n  = mq.size();
    fr = 8 - n;
    r0 = !fl && (fr >= 1);
    r1 = !fl && (fr >= (v0 ? 2 : 1));
    np = (st || fl) ? 0 : ((n < 2) ? n : 2);
    chk("in0_ready", in0_ready, r0);
    chk("in1_ready", in1_ready, r1);
    chk("we0", we0, np >= 1);
    chk("we1", we1, np == 2);
    if (np >= 1) begin
      chk("waddr0", waddr0, mq[0].a);
      chk("wdata0", wdata0, mq[0].d);
    end else begin
      chk("waddr0_zero", waddr0, 0);
      chk("wdata0_zero", wdata0, 0);
    end
    if (np == 2) begin
      chk("waddr1", waddr1, mq[1].a);
      chk("wdata1", wdata1, mq[1].d);
    end else begin
      chk("waddr1_zero", waddr1, 0);
      chk("wdata1_zero", wdata1, 0);
    end
    chk("count", count, n);
    chk("empty", empty, n == 0);
`ifdef WBQ_PERF_EN
    chk("perf_bp", perf_bp, m_perf);
`endif
    @(posedge clk);
    if (((v0 && !r0) || (v1 && !r1)) && (m_perf != 32'hFFFF_FFFF)) m_perf++;
    if (fl) begin
      mq.delete();
    end else begin
      repeat (np) void'(mq.pop_front());
      if (v0 && r0 && a0 != 0) begin e.a = a0; e.d = d0; mq.push_back(e); end
      if (v1 && r1 && a1 != 0) begin e.a = a1; e.d = d1; mq.push_back(e); end
    end
  endtask

  task automatic idle(input logic st);
    step(1'b0, st, 1'b0, 6'd0, 64'd0, 1'b0, 6'd0, 64'd0);
  endtask

  task automatic push_pair_stalled();
    step(1'b0, 1'b1, 1'b1, 6'($urandom_range(1, 32)), rnd64(),
                     1'b1, 6'($urandom_range(1, 32)), rnd64());
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; stall = 1'b0;
    in0_valid = 1'b0; in0_waddr = '0; in0_wdata = '0;
    in1_valid = 1'b0; in1_waddr = '0; in1_wdata = '0;
    m_perf = '0;
    #1;
    chk("rst_we0", we0, 0);
    chk("rst_we1", we1, 0);
    chk("rst_waddr0", waddr0, 0);
    chk("rst_wdata1", wdata1, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_in0_ready", in0_ready, 1);
    chk("rst_in1_ready", in1_ready, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(1'b0);

    // Dual push into an empty queue, visible one cycle later on both ports.
    step(1'b0, 1'b0, 1'b1, 6'd5, 64'h11, 1'b1, 6'd32, 64'h0000_0002_0000_0003);
    #1;
    chk("dp_we0", we0, 1);
    chk("dp_waddr0", waddr0, 5);
    chk("dp_wdata0", wdata0, 64'h11);
    chk("dp_we1", we1, 1);
    chk("dp_waddr1", waddr1, 32);
    chk("dp_wdata1", wdata1, 64'h0000_0002_0000_0003);
    idle(1'b0);
    #1;
    chk("dp_drained", count, 0);

    // Fill under stall, then drain; second fill exercises pointer wrap.
    repeat (2) begin
      repeat (4) push_pair_stalled();
      #1;
      chk("fill_count", count, 8);
      chk("fill_in0_ready", in0_ready, 0);
      chk("fill_we0", we0, 0);
      push_pair_stalled();
      repeat (4) idle(1'b0);
      #1;
      chk("fill_drained", empty, 1);
      step(1'b0, 1'b0, 1'b1, 6'd4, rnd64(), 1'b0, 6'd0, 64'd0);
    end
    idle(1'b0);

    // Same-address pair: port 1 carries the younger value.
    step(1'b0, 1'b0, 1'b1, 6'd7, 64'hA, 1'b1, 6'd7, 64'hB);
    #1;
    chk("sa_waddr0", waddr0, 7);
    chk("sa_waddr1", waddr1, 7);
    chk("sa_wdata0", wdata0, 64'hA);
    chk("sa_wdata1", wdata1, 64'hB);
    idle(1'b0);

    // Address 0 dropped while in1 is stored.
    step(1'b0, 1'b0, 1'b1, 6'd0, 64'hFF, 1'b1, 6'd9, 64'h9);
    #1;
    chk("a0_count", count, 1);
    chk("a0_we0", we0, 1);
    chk("a0_waddr0", waddr0, 9);
    chk("a0_we1", we1, 0);
    idle(1'b0);

    // count=7, in0 idle: in1 alone fits.
    repeat (3) push_pair_stalled();
    step(1'b0, 1'b1, 1'b1, 6'd3, rnd64(), 1'b0, 6'd0, 64'd0);
    step(1'b0, 1'b1, 1'b0, 6'd0, 64'd0, 1'b1, 6'd12, 64'h12);
    #1;
    chk("c7_count", count, 8);
    repeat (4) idle(1'b0);

    // Flush with count=5 and both valids high.
    repeat (2) push_pair_stalled();
    step(1'b0, 1'b1, 1'b1, 6'd6, rnd64(), 1'b0, 6'd0, 64'd0);
    step(1'b1, 1'b1, 1'b1, 6'd8, rnd64(), 1'b1, 6'd9, rnd64());
    #1;
    chk("fl_count", count, 0);
    idle(1'b0);

    // Asynchronous reset between edges.
    repeat (2) push_pair_stalled();
    @(negedge clk);
    stall = 1'b0; in0_valid = 1'b0; in1_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("ar_we0", we0, 0);
    chk("ar_waddr0", waddr0, 0);
    chk("ar_count", count, 0);
    chk("ar_empty", empty, 1);
    mq.delete();
    m_perf = '0;
    @(negedge clk);
    rst = 1'b0;
    idle(1'b0);

    // Random traffic.
    repeat (600) begin
      step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) != 0), rnd_addr(), rnd64(),
           ($urandom_range(0, 3) != 0), rnd_addr(), rnd64());
    end
    repeat (6) idle(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
